// File: rtl/sprdma.sv
// ---------------------------------------------------------------------------
// sprdma - NES sprite DMA engine.
//
// Snoops CPU writes to $4014 on the cpumc bus. On such a write it latches the
// page number, raises 'active' (which stalls the CPU and switches the cpumc
// bus mux to this block) and copies $XX00-$XXFF into the PPU OAM data port
// ($2004): one read-address cycle, one read-data cycle, one write cycle per
// byte.
//
// Ports:
//   clk            50 MHz system clock
//   rst_n          asynchronous active-low reset
//   cpumc_a_in     snooped cpumc address bus
//   cpumc_din_in   snooped cpumc write data
//   cpumc_r_nw_in  snooped cpumc R/!W
//   cpu_din_in     read-return data (valid one clock after the address)
//   active         high while the DMA owns the bus
//   a_out          DMA address
//   dout           DMA write data
//   r_nw_out       DMA R/!W
//
// Optional feature macro: SPRDMA_ODD_ALIGN_EN
//   When defined, a free-running cycle-parity bit stretches START to two
//   cycles if the trigger lands on an odd cycle (513/514-cycle NES behaviour).
// ---------------------------------------------------------------------------
module sprdma (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpumc_a_in,
    input  logic [7:0]  cpumc_din_in,
    input  logic        cpumc_r_nw_in,
    input  logic [7:0]  cpu_din_in,
    output logic        active,
    output logic [15:0] a_out,
    output logic [7:0]  dout,
    output logic        r_nw_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_WR      = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  page_r, page_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [7:0]  data_q_r, data_q_s;
    logic        active_r, active_s;
    logic [15:0] a_out_r, a_out_s;
    logic [7:0]  dout_r, dout_s;
    logic        r_nw_r, r_nw_s;
    logic        trigger_s;

`ifdef SPRDMA_ODD_ALIGN_EN
    logic        parity_r;
    logic        start_ext_r, start_ext_s;

    // Free-running cycle parity used to decide whether START is stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= ~parity_r;
        end
    end
`endif

    assign trigger_s = (cpumc_a_in == 16'h4014) && (cpumc_r_nw_in == 1'b0);

    // Next-state logic; output values are computed from the next state so
    // that every output comes straight from a flop.
    always_comb begin
        state_s  = state_r;
        page_s   = page_r;
        cnt_s    = cnt_r;
        data_q_s = data_q_r;
`ifdef SPRDMA_ODD_ALIGN_EN
        start_ext_s = start_ext_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (trigger_s) begin
                    state_s = S_START;
                    page_s  = cpumc_din_in;
                    cnt_s   = 8'h00;
`ifdef SPRDMA_ODD_ALIGN_EN
                    start_ext_s = parity_r;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
`ifdef SPRDMA_ODD_ALIGN_EN
                if (start_ext_r) begin
                    start_ext_s = 1'b0;
                end else begin
                    state_s = S_RD_ADDR;
                end
`else
                state_s = S_RD_ADDR;
`endif
            end
            S_RD_ADDR: begin
                state_s = S_RD_DATA;
            end
            S_RD_DATA: begin
                // One-clock read latency: data is valid during this cycle.
                data_q_s = cpu_din_in;
                state_s  = S_WR;
            end
            S_WR: begin
                // The transfer ends at the 8-bit wrap; no ninth address bit.
                if (cnt_r == 8'hFF) begin
                    state_s = S_IDLE;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                    state_s = S_RD_ADDR;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Idle/start drive a harmless read of $0000.
        active_s = 1'b1;
        a_out_s  = 16'h0000;
        dout_s   = 8'h00;
        r_nw_s   = 1'b1;
        case (state_s)
            S_IDLE: begin
                active_s = 1'b0;
            end
            S_START: begin
                active_s = 1'b1;
            end
            S_RD_ADDR, S_RD_DATA: begin
                a_out_s = {page_s, cnt_s};
            end
            S_WR: begin
                a_out_s = 16'h2004;
                dout_s  = data_q_s;
                r_nw_s  = 1'b0;
            end
            default: begin
                active_s = 1'b0;
            end
        endcase
    end

    // State, transfer registers and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            page_r   <= 8'h00;
            cnt_r    <= 8'h00;
            data_q_r <= 8'h00;
            active_r <= 1'b0;
            a_out_r  <= 16'h0000;
            dout_r   <= 8'h00;
            r_nw_r   <= 1'b1;
`ifdef SPRDMA_ODD_ALIGN_EN
            start_ext_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            page_r   <= page_s;
            cnt_r    <= cnt_s;
            data_q_r <= data_q_s;
            active_r <= active_s;
            a_out_r  <= a_out_s;
            dout_r   <= dout_s;
            r_nw_r   <= r_nw_s;
`ifdef SPRDMA_ODD_ALIGN_EN
            start_ext_r <= start_ext_s;
`endif
        end
    end

    assign active   = active_r;
    assign a_out    = a_out_r;
    assign dout     = dout_r;
    assign r_nw_out = r_nw_r;

endmodule
